// File: rtl/result_bcd_formatter_if.sv
// Handshake bundle between the sign-magnitude result stage, the BCD formatter and its consumer.
// With RESULT_BCD_FORMATTER_BLANK_EN defined, the bundle also carries the per-digit blanking flags.
interface result_bcd_formatter_if #(
    parameter int MAG_WIDTH = 9,
    parameter int DIGITS    = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [MAG_WIDTH-1:0]  in_mag;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  busy;
`ifdef RESULT_BCD_FORMATTER_BLANK_EN
    logic [DIGITS-1:0]     digit_blank;

    modport master (
        output in_valid, in_sign, in_mag, out_ready,
        input  in_ready, out_valid, out_sign, out_bcd, busy, digit_blank
    );

    modport slave (
        input  in_valid, in_sign, in_mag, out_ready,
        output in_ready, out_valid, out_sign, out_bcd, busy, digit_blank
    );
`else
    modport master (
        output in_valid, in_sign, in_mag, out_ready,
        input  in_ready, out_valid, out_sign, out_bcd, busy
    );

    modport slave (
        input  in_valid, in_sign, in_mag, out_ready,
        output in_ready, out_valid, out_sign, out_bcd, busy
    );
`endif
endinterface

// File: rtl/result_bcd_formatter.sv
// Sign-magnitude to packed BCD formatter using a serial double-dabble engine, one magnitude bit per clock.
// Define RESULT_BCD_FORMATTER_BLANK_EN to add registered leading-zero blanking flags (digit_blank).
module result_bcd_formatter #(
    parameter int MAG_WIDTH = 9,
    parameter int DIGITS    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    result_bcd_formatter_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(MAG_WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned MAX_MAG = (64'd1 << MAG_WIDTH) - 64'd1;

    // The digit count must be able to represent the largest magnitude.
    generate
        if (pow10(DIGITS) <= MAX_MAG) begin : g_bad_cfg
            $error("result_bcd_formatter: DIGITS too small for MAG_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [BCD_W-1:0]       r_bcd;
    logic [MAG_WIDTH-1:0]   r_mag;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sign_cap;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;
    logic                   r_out_sign;
    logic [BCD_W-1:0]       r_out_bcd;

    logic [BCD_W-1:0]           w_bcd_adj;
    logic [BCD_W+MAG_WIDTH-1:0] w_shift;
    logic [BCD_W-1:0]           w_bcd_next;
    logic [MAG_WIDTH-1:0]       w_mag_next;

    // Add-3 correction on every nibble >= 5, then shift the magnitude MSB into BCD bit 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_shift    = {w_bcd_adj, r_mag} << 1;
        w_bcd_next = w_shift[BCD_W+MAG_WIDTH-1 : MAG_WIDTH];
        w_mag_next = w_shift[MAG_WIDTH-1:0];
    end

`ifdef RESULT_BCD_FORMATTER_BLANK_EN
    logic [DIGITS-1:0] r_digit_blank;
    logic [DIGITS-1:0] w_blank_next;

    // A digit blanks only when it and every higher digit are zero; the ones digit never blanks.
    always_comb begin
        logic zero_above;
        zero_above   = 1'b1;
        w_blank_next = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_above      = zero_above & (w_bcd_next[4*d +: 4] == 4'd0);
            w_blank_next[d] = zero_above;
        end
    end

    assign bus.digit_blank = r_digit_blank;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state     <= S_IDLE;
            r_bcd       <= '0;
            r_mag       <= '0;
            r_cnt       <= '0;
            r_sign_cap  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_bcd   <= '0;
`ifdef RESULT_BCD_FORMATTER_BLANK_EN
            r_digit_blank <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign_cap <= bus.in_sign;
                        r_mag      <= bus.in_mag;
                        r_bcd      <= '0;
                        r_cnt      <= CNT_W'(MAG_WIDTH);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_mag <= w_mag_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_bcd   <= w_bcd_next;
                        r_out_sign  <= r_sign_cap;
`ifdef RESULT_BCD_FORMATTER_BLANK_EN
                        r_digit_blank <= w_blank_next;
`endif
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No re-accept on the handshake edge; IDLE is entered first.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out_sign  = r_out_sign;
    assign bus.out_bcd   = r_out_bcd;

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Directed self-checking bench for result_bcd_formatter: vector table plus hold, ignore, abort and streaming sequences.
// Blanking checks are compiled in when RESULT_BCD_FORMATTER_BLANK_EN is defined.
module tb_result_bcd_formatter;
    localparam int MAG_WIDTH = 9;
    localparam int DIGITS    = 3;
    localparam int LATENCY   = MAG_WIDTH;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    result_bcd_formatter_if #(.MAG_WIDTH(MAG_WIDTH), .DIGITS(DIGITS)) bus_if ();

    result_bcd_formatter #(.MAG_WIDTH(MAG_WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [8:0]  mag;
        logic [11:0] bcd;
        logic [2:0]  blank;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one input for exactly one accepting edge; returns at the negedge after acceptance.
    task automatic start(input logic sign, input logic [8:0] mag, input string name);
        bus_if.in_sign  = sign;
        bus_if.in_mag   = mag;
        bus_if.in_valid = 1'b1;
        check({name, " in_ready idle"}, {31'd0, bus_if.in_ready}, 32'd1);
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.in_mag   = 9'h1AA;
        check({name, " in_ready after accept"}, {31'd0, bus_if.in_ready}, 32'd0);
    endtask

    // Counts edges until out_valid rises (bounded) and checks the result.
    task automatic wait_result(input int exp_lat, input logic sign, input logic [11:0] bcd,
                               input logic [2:0] blank, input string name);
        int k;
        k = 0;
        while (!bus_if.out_valid && k < 40) begin
            check({name, " busy in shift"}, {31'd0, bus_if.busy}, 32'd1);
            tick();
            k++;
        end
        check({name, " latency"}, k, exp_lat);
        check({name, " out_bcd"}, {20'd0, bus_if.out_bcd}, {20'd0, bcd});
        check({name, " out_sign"}, {31'd0, bus_if.out_sign}, {31'd0, sign});
        check({name, " busy in done"}, {31'd0, bus_if.busy}, 32'd0);
`ifdef RESULT_BCD_FORMATTER_BLANK_EN
        check({name, " digit_blank"}, {29'd0, bus_if.digit_blank}, {29'd0, blank});
`else
        if (blank === 3'bxxx) $display("unexpected blank pattern");
`endif
    endtask

    task automatic handshake(input string name);
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check({name, " out_valid after hs"}, {31'd0, bus_if.out_valid}, 32'd0);
        check({name, " in_ready after hs"}, {31'd0, bus_if.in_ready}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{sign: 1'b0, mag: 9'd0,   bcd: 12'h000, blank: 3'b110};
        vecs[1] = '{sign: 1'b0, mag: 9'd511, bcd: 12'h511, blank: 3'b000};
        vecs[2] = '{sign: 1'b1, mag: 9'd255, bcd: 12'h255, blank: 3'b000};
        vecs[3] = '{sign: 1'b1, mag: 9'd0,   bcd: 12'h000, blank: 3'b110};
        vecs[4] = '{sign: 1'b0, mag: 9'd9,   bcd: 12'h009, blank: 3'b110};
        vecs[5] = '{sign: 1'b1, mag: 9'd58,  bcd: 12'h058, blank: 3'b100};
        vecs[6] = '{sign: 1'b0, mag: 9'd499, bcd: 12'h499, blank: 3'b000};
        vecs[7] = '{sign: 1'b0, mag: 9'd305, bcd: 12'h305, blank: 3'b000};

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_sign   = 1'b0;
        bus_if.in_mag    = '0;
        bus_if.out_ready = 1'b0;
        repeat (3) tick();
        check("reset in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("reset out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("reset busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset out_sign", {31'd0, bus_if.out_sign}, 32'd0);
        check("reset out_bcd", {20'd0, bus_if.out_bcd}, 32'd0);
`ifdef RESULT_BCD_FORMATTER_BLANK_EN
        check("reset digit_blank", {29'd0, bus_if.digit_blank}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start(vecs[i].sign, vecs[i].mag, nm);
            wait_result(LATENCY, vecs[i].sign, vecs[i].bcd, vecs[i].blank, nm);
            handshake(nm);
            tick();
        end

        // Result held while the consumer stalls for 20 cycles.
        start(1'b0, 9'd7, "hold");
        wait_result(LATENCY, 1'b0, 12'h007, 3'b110, "hold");
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold out_valid", {31'd0, bus_if.out_valid}, 32'd1);
            check("hold out_bcd", {20'd0, bus_if.out_bcd}, 32'h007);
            check("hold in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        end
        handshake("hold");

        // New input offered mid-conversion must be ignored.
        start(1'b1, 9'd42, "ignore");
        tick();
        bus_if.in_valid = 1'b1;
        bus_if.in_sign  = 1'b0;
        bus_if.in_mag   = 9'd100;
        check("ignore in_ready in shift", {31'd0, bus_if.in_ready}, 32'd0);
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        wait_result(LATENCY - 3, 1'b1, 12'h042, 3'b100, "ignore");
        check("ignore in_ready in done", {31'd0, bus_if.in_ready}, 32'd0);
        handshake("ignore");
        repeat (3) tick();
        check("ignore no restart busy", {31'd0, bus_if.busy}, 32'd0);
        check("ignore no restart valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Reset on the fourth SHIFT edge aborts the conversion.
        start(1'b0, 9'd511, "abort");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("abort out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("abort busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort out_sign", {31'd0, bus_if.out_sign}, 32'd0);
        check("abort out_bcd", {20'd0, bus_if.out_bcd}, 32'd0);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("abort no out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        end
        start(1'b0, 9'd99, "after abort");
        wait_result(LATENCY, 1'b0, 12'h099, 3'b100, "after abort");
        handshake("after abort");
        tick();

        // Streaming with out_ready and in_valid held high: one result every MAG_WIDTH+2 cycles.
        begin
            logic [8:0]  mags[3];
            logic [11:0] exps[3];
            int idx, got, cyc, last_cyc;
            logic acc_pending;
            mags[0] = 9'd1;    exps[0] = 12'h001;
            mags[1] = 9'd10;   exps[1] = 12'h010;
            mags[2] = 9'd100;  exps[2] = 12'h100;
            idx = 0; got = 0; last_cyc = 0; acc_pending = 1'b0;
            bus_if.out_ready = 1'b1;
            bus_if.in_sign   = 1'b0;
            bus_if.in_mag    = mags[0];
            bus_if.in_valid  = 1'b1;
            for (cyc = 0; cyc < 80 && got < 3; cyc++) begin
                if (acc_pending) begin
                    idx++;
                    acc_pending = 1'b0;
                    if (idx < 3) bus_if.in_mag = mags[idx];
                    else bus_if.in_valid = 1'b0;
                end
                if (bus_if.out_valid) begin
                    check($sformatf("stream out_bcd %0d", got), {20'd0, bus_if.out_bcd}, {20'd0, exps[got]});
                    if (got > 0) check($sformatf("stream spacing %0d", got), cyc - last_cyc, MAG_WIDTH + 2);
                    last_cyc = cyc;
                    got++;
                end
                if (bus_if.in_valid && bus_if.in_ready) acc_pending = 1'b1;
                tick();
            end
            check("stream result count", got, 3);
            bus_if.out_ready = 1'b0;
            bus_if.in_valid  = 1'b0;
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
